// File: rtl/wb_regfile_pkg.sv
// Shared core definitions for the writeback stage: datapath widths and
// the resultSrc encodings that select the value written back.
package wb_regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RESULT_ALU  = 2'b00,
        RESULT_LOAD = 2'b01,
        RESULT_PC4  = 2'b10,
        RESULT_IMM  = 2'b11
    } result_src_e;

    // A write commits only when enabled and not aimed at the hardwired x0.
    function automatic logic write_commits(input logic                  we,
                                           input logic [REG_ADDR_W-1:0] addr);
        return we && (addr != '0);
    endfunction

endpackage

// File: rtl/wb_result_mux.sv
// 4:1 writeback result select; purely combinational so result_WB can feed
// both the register file bypass and the forwarding network in one cycle.
module wb_result_mux
    import wb_regfile_pkg::*;
(
    input  logic [1:0]      result_src,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] load_out,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = alu_result;
        case (result_src)
            RESULT_ALU:  result = alu_result;
            RESULT_LOAD: result = load_out;
            RESULT_PC4:  result = pc_plus4;
            RESULT_IMM:  result = imm_out;
            default:     result = alu_result;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: x1..x31 storage, two combinational read
// ports with same-cycle write bypass, and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  regWrite_WB,
    input  logic [1:0]            resultSrc_WB,
    input  logic [XLEN-1:0]       ALUResult_WB,
    input  logic [XLEN-1:0]       loadOut_WB,
    input  logic [XLEN-1:0]       immOut_WB,
    input  logic [XLEN-1:0]       PCPlus4_WB,
    input  logic [REG_ADDR_W-1:0] writeAddress_WB,
    input  logic [REG_ADDR_W-1:0] readAddress1_ID,
    input  logic [REG_ADDR_W-1:0] readAddress2_ID,
    output logic [XLEN-1:0]       readData1_ID,
    output logic [XLEN-1:0]       readData2_ID,
    output logic [XLEN-1:0]       result_WB,
    output logic [XLEN-1:0]       retiredWrites
);

    logic [XLEN-1:0] regs [1:31];
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] retired_cnt;
    logic            write_en;

    wb_result_mux u_result_mux (
        .result_src (resultSrc_WB),
        .alu_result (ALUResult_WB),
        .load_out   (loadOut_WB),
        .pc_plus4   (PCPlus4_WB),
        .imm_out    (immOut_WB),
        .result     (result)
    );

    assign result_WB     = result;
    assign retiredWrites = retired_cnt;
    assign write_en      = write_commits(regWrite_WB, writeAddress_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            retired_cnt <= '0;
        end else if (write_en) begin
            regs[writeAddress_WB] <= result;
            retired_cnt           <= retired_cnt + 1'b1;
        end
    end

    // Reads are forced to zero while in reset so a pending write cannot
    // leak through the bypass before storage is usable.
    always_comb begin
        readData1_ID = '0;
        if (rst_n && (readAddress1_ID != '0)) begin
            if (write_en && (readAddress1_ID == writeAddress_WB)) begin
                readData1_ID = result;
            end else begin
                readData1_ID = regs[readAddress1_ID];
            end
        end
    end

    always_comb begin
        readData2_ID = '0;
        if (rst_n && (readAddress2_ID != '0)) begin
            if (write_en && (readAddress2_ID == writeAddress_WB)) begin
                readData2_ID = result;
            end else begin
                readData2_ID = regs[readAddress2_ID];
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        regWrite_WB;
    logic [1:0]  resultSrc_WB;
    logic [31:0] ALUResult_WB;
    logic [31:0] loadOut_WB;
    logic [31:0] immOut_WB;
    logic [31:0] PCPlus4_WB;
    logic [4:0]  writeAddress_WB;
    logic [4:0]  readAddress1_ID;
    logic [4:0]  readAddress2_ID;
    logic [31:0] readData1_ID;
    logic [31:0] readData2_ID;
    logic [31:0] result_WB;
    logic [31:0] retiredWrites;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Reference model state
    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;
    logic [31:0] cnt_bias = '0;

    wb_regfile dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .regWrite_WB     (regWrite_WB),
        .resultSrc_WB    (resultSrc_WB),
        .ALUResult_WB    (ALUResult_WB),
        .loadOut_WB      (loadOut_WB),
        .immOut_WB       (immOut_WB),
        .PCPlus4_WB      (PCPlus4_WB),
        .writeAddress_WB (writeAddress_WB),
        .readAddress1_ID (readAddress1_ID),
        .readAddress2_ID (readAddress2_ID),
        .readData1_ID    (readData1_ID),
        .readData2_ID    (readData2_ID),
        .result_WB       (result_WB),
        .retiredWrites   (retiredWrites)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result();
        logic [31:0] cand [4];
        cand[0] = ALUResult_WB;
        cand[1] = loadOut_WB;
        cand[2] = PCPlus4_WB;
        cand[3] = immOut_WB;
        return cand[resultSrc_WB];
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (!rst_n || addr == 0) return 32'h0;
        if (regWrite_WB && writeAddress_WB != 0 && writeAddress_WB == addr) return model_result();
        return model_regs[addr];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model_regs[i] = '0;
            model_cnt = '0;
        end else if (regWrite_WB && writeAddress_WB != 0) begin
            model_regs[writeAddress_WB] = model_result();
            model_cnt = model_cnt + 1;
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check32("cmp_result", result_WB, model_result());
            check32("cmp_rd1", readData1_ID, model_read(readAddress1_ID));
            check32("cmp_rd2", readData2_ID, model_read(readAddress2_ID));
            check32("cmp_count", retiredWrites, rst_n ? model_cnt + cnt_bias : 32'h0);
        end
    end

    // Driver tasks
    task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [4:0] wa, input logic [4:0] ra1, input logic [4:0] ra2);
        regWrite_WB = we; resultSrc_WB = src; ALUResult_WB = alu; loadOut_WB = ld;
        PCPlus4_WB = pc4; immOut_WB = imm; writeAddress_WB = wa;
        readAddress1_ID = ra1; readAddress2_ID = ra2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_then_read(input logic [1:0] src, input logic [31:0] val,
                                   input logic [4:0] wa, input logic [31:0] exp_cnt, input string name);
        logic [31:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = 32'hA5A50000 | i;
        v[src] = val;
        drive(1, src, v[0], v[1], v[2], v[3], wa, 0, 0);
        #1 check32({name, "_mux"}, result_WB, val);
        step();
        regWrite_WB = 0; readAddress1_ID = wa;
        #1 check32({name, "_rd1"}, readData1_ID, val);
        check32({name, "_cnt"}, retiredWrites, exp_cnt);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        cmp_en = 1;

        // Reset-and-read
        readAddress1_ID = 5; readAddress2_ID = 31;
        #1 check32("rst_x5", readData1_ID, 0);
        check32("rst_x31", readData2_ID, 0);
        check32("rst_cnt", retiredWrites, 0);

        // Write-then-read per source
        write_then_read(2'b01, 32'hDEADBEEF, 7, 1, "wr_load");
        write_then_read(2'b00, 32'h11111111, 8, 2, "wr_alu");
        write_then_read(2'b10, 32'h22222222, 9, 3, "wr_pc4");
        write_then_read(2'b11, 32'h33333333, 10, 4, "wr_imm");

        // Bypass on both ports, same register
        step();
        drive(1, 0, 32'h12345678, 1, 2, 3, 3, 3, 3);
        #1 check32("byp_rd1", readData1_ID, 32'h12345678);
        check32("byp_rd2", readData2_ID, 32'h12345678);
        step();
        regWrite_WB = 0;
        #1 check32("byp_stored", readData2_ID, 32'h12345678);
        check32("byp_cnt", retiredWrites, 5);

        // x0 write is a no-op
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        #1 check32("x0_before", readData1_ID, 0);
        check32("x0_mux", result_WB, 32'hFFFFFFFF);
        step();
        regWrite_WB = 0;
        #1 check32("x0_after", readData1_ID, 0);
        check32("x0_cnt", retiredWrites, 5);

        // Fill every register, then reset between edges
        for (int i = 1; i < 32; i++) begin
            drive(1, 2'b11, 0, 0, 0, 32'h01000000 * i + i, i[4:0], 0, 0);
            step();
        end
        regWrite_WB = 0; readAddress1_ID = 31; readAddress2_ID = 1;
        #1 check32("fill_x31", readData1_ID, 32'h1F00001F);
        check32("fill_x1", readData2_ID, 32'h01000001);
        check32("fill_cnt", retiredWrites, 36);
        @(negedge clk);
        #2;
        regWrite_WB = 1; writeAddress_WB = 12;
        rst_n = 0;
        for (int i = 0; i < 32; i++) begin
            readAddress1_ID = i[4:0]; readAddress2_ID = 5'(31 - i);
            #1 check32("midrst_rd1", readData1_ID, 0);
            check32("midrst_rd2", readData2_ID, 0);
        end
        check32("midrst_cnt", retiredWrites, 0);
        step();
        regWrite_WB = 0;
        rst_n = 1;
        readAddress1_ID = 12;
        step();
        check32("postrst_x12", readData1_ID, 0);
        check32("postrst_cnt", retiredWrites, 0);

        // Counter wrap via preload
        @(negedge clk);
        #2;
        force dut.retired_cnt = 32'hFFFFFFFF;
        #1 release dut.retired_cnt;
        cnt_bias = 32'hFFFFFFFF - model_cnt;
        #1 check32("wrap_preload", retiredWrites, 32'hFFFFFFFF);
        drive(1, 0, 32'hCAFEF00D, 0, 0, 0, 4, 4, 0);
        step();
        regWrite_WB = 0;
        #1 check32("wrap_cnt", retiredWrites, 0);
        check32("wrap_x4", readData1_ID, 32'hCAFEF00D);

        // Randomized traffic, scoreboard checks every cycle
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom, $urandom, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                  5'($urandom_range(0, 7)));
            step();
        end

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
